rca_wb_sequencer: RTL
=====================

RCA_WB_SEQUENCER -- requirements
Module: rca_wb_sequencer

Interface
REQ-001 Parameter NUM_IO_UNITS, default 8, number of grid IO units.
REQ-002 Parameter NUM_WRITE_PORTS, default 2, number of register-file write ports.
REQ-003 Parameter DEPTH, default 4 (power of two, at least 2), number of pending-writeback queue entries.
REQ-004 Parameter SW, default $clog2(NUM_IO_UNITS), width of one IO-unit select.
REQ-005 clk  in  1  Sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  Reset, asynchronous assert, active-low.
REQ-007 flush  in  1  Synchronous discard of all pending writebacks.
REQ-008 issue_valid  in  1  Issue stage presents one writeback descriptor.
REQ-009 issue_ready  out  1  Queue can accept a descriptor.
REQ-010 issue_sels  in  NUM_WRITE_PORTS*SW  IO-unit select per port; port i occupies bits [i*SW +: SW].
REQ-011 issue_port_en  in  NUM_WRITE_PORTS  Per-port use mask; a disabled port is ignored.
REQ-012 issue_rd  in  NUM_WRITE_PORTS*5  Destination register per port.
REQ-013 unit_valid  in  NUM_IO_UNITS  Per-IO-unit output-data-valid.
REQ-014 unit_consume  out  NUM_IO_UNITS  One-cycle pulse to each unit whose data is committed.
REQ-015 wb_sels  out  NUM_WRITE_PORTS*SW  Head-entry selects driving the writeback datapath muxes.
REQ-016 wb_sels_valid  out  1  Queue is not empty.
REQ-017 rf_ready  in  1  Register file accepts writes this cycle.
REQ-018 rf_we  out  NUM_WRITE_PORTS  Per-port write enable, asserted only on a commit.
REQ-019 rf_rd  out  NUM_WRITE_PORTS*5  Head-entry destination registers.
REQ-020 timeout_err  out  1  Sticky head-stall error; present only with RCA_WB_TIMEOUT_EN.

Function
REQ-021 The queue SHALL be a circular FIFO of DEPTH entries holding {sels, port_en, rd}, with read/write pointers one bit wider than log2(DEPTH) and wrapping modulo 2*DEPTH.
REQ-022 issue_ready SHALL be !full; a push occurs when issue_valid && issue_ready, and there is no same-cycle pass-through when full.
REQ-023 The head entry SHALL be ready when, for every port i with port_en[i]=1, unit_valid[sels[i]]=1; an entry with port_en=0 is ready immediately.
REQ-024 A commit SHALL occur when !empty && head ready && rf_ready && !flush.
REQ-025 On a commit: rf_we = head port_en; unit_consume = OR of one-hot(sels[i]) over the enabled ports; the head is popped at the clock edge. Outside a commit, rf_we and unit_consume are 0.
REQ-026 A descriptor pushed into an empty queue SHALL commit no earlier than the following cycle (minimum latency 1 cycle).
REQ-027 A simultaneous push and commit SHALL leave the occupancy unchanged; a push is accepted in a full cycle only through issue_ready, never by a same-cycle pop.
REQ-028 FSM states: EMPTY (no entries), WAIT (head not ready), STALL (head ready, rf_ready=0), COMMIT (commit this cycle); the state is a registered decode of occupancy plus a combinational qualifier.
REQ-029 wb_sels and rf_rd SHALL show the head entry whenever wb_sels_valid=1, and SHALL hold the last values otherwise.
REQ-030 flush SHALL take priority over push and commit: it empties the queue at the next edge, suppresses rf_we and unit_consume in the flush cycle, and ignores any push presented that cycle.

Reset
REQ-031 While rst_n=0: pointers are 0, queue empty, issue_ready=1, wb_sels_valid=0, rf_we=0, unit_consume=0, wb_sels=0, rf_rd=0, timeout counter=0, timeout_err=0.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge; no commit occurs after deassertion until a new push.

Configuration
REQ-033 With macro RCA_WB_TIMEOUT_EN defined: a 10-bit counter increments each cycle the queue is non-empty and no commit occurs, and clears on commit or flush. At the value 1023 it sets timeout_err, which stays set until reset.
REQ-034 With RCA_WB_TIMEOUT_EN undefined: no counter exists and timeout_err is tied to 0.

Verification
REQ-035 Reset, then push {sels=(3,5), port_en=11, rd=(7,9)}; raise unit_valid[3] at cycle 2 and unit_valid[5] at cycle 4, rf_ready=1 -> single-cycle rf_we=11, rf_rd=(7,9), unit_consume=0x28 at cycle 4; queue empty at cycle 5.
REQ-036 Push 4 entries with all unit_valid=0 -> issue_ready=0 after the 4th; a 5th issue_valid is not accepted. Then set unit_valid=all-ones -> 4 commits on consecutive cycles, in order.
REQ-037 Head ready, rf_ready held low for 3 cycles -> no rf_we and no unit_consume during STALL; commit on the first cycle rf_ready=1.
REQ-038 Queue holding 3 entries, flush asserted together with issue_valid -> no commit that cycle; the next cycle shows wb_sels_valid=0 and issue_ready=1.
REQ-039 Push an entry with port_en=00 -> it commits on the next cycle with rf_we=00 and unit_consume=0.
REQ-040 RCA_WB_TIMEOUT_EN defined, head never ready -> timeout_err rises after 1023 non-empty cycles and remains set through a later flush.

Source files
------------

// File: rtl/rca_wb_sequencer.sv
// Writeback sequencer: queues issue-time writeback descriptors and commits the head once its IO units are valid.
// Optional macro RCA_WB_TIMEOUT_EN adds a sticky head-stall timeout (timeout_err).
module rca_wb_sequencer #(
  parameter int NUM_IO_UNITS    = 8,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int DEPTH           = 4,
  parameter int SW              = $clog2(NUM_IO_UNITS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  logic [NUM_WRITE_PORTS*SW-1:0]   issue_sels,
  input  logic [NUM_WRITE_PORTS-1:0]      issue_port_en,
  input  logic [NUM_WRITE_PORTS*5-1:0]    issue_rd,
  input  logic [NUM_IO_UNITS-1:0]         unit_valid,
  output logic [NUM_IO_UNITS-1:0]         unit_consume,
  output logic [NUM_WRITE_PORTS*SW-1:0]   wb_sels,
  output logic                            wb_sels_valid,
  input  logic                            rf_ready,
  output logic [NUM_WRITE_PORTS-1:0]      rf_we,
  output logic [NUM_WRITE_PORTS*5-1:0]    rf_rd,
  output logic                            timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {EMPTY, WAIT, STALL, COMMIT} state_t;

  // Handshake: a descriptor transfers on a rising edge where issue_valid && issue_ready && !flush;
  // issue_ready depends only on registered occupancy, so a full queue never accepts via a same-cycle pop.

  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [NUM_WRITE_PORTS*SW-1:0] sels_mem [DEPTH];
  logic [NUM_WRITE_PORTS-1:0]    en_mem   [DEPTH];
  logic [NUM_WRITE_PORTS*5-1:0]  rd_mem   [DEPTH];
  logic [NUM_WRITE_PORTS*SW-1:0] sels_hold;
  logic [NUM_WRITE_PORTS*5-1:0]  rd_hold;

  logic [NUM_WRITE_PORTS*SW-1:0] head_sels;
  logic [NUM_WRITE_PORTS-1:0]    head_en;
  logic [NUM_WRITE_PORTS*5-1:0]  head_rd;
  logic                          empty, full, head_ready, push, commit;
  state_t                        state;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign head_sels = sels_mem[rd_ptr[AW-1:0]];
  assign head_en   = en_mem[rd_ptr[AW-1:0]];
  assign head_rd   = rd_mem[rd_ptr[AW-1:0]];

  assign issue_ready   = !full;
  assign push          = issue_valid && !full && !flush;
  assign wb_sels_valid = !empty;

  always_comb begin
    head_ready = 1'b1;
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      if (head_en[i] && !unit_valid[head_sels[i*SW +: SW]]) head_ready = 1'b0;
    end
  end

  // Occupancy comes from the registered pointers; readiness and rf_ready qualify it within the cycle.
  always_comb begin
    if (empty)                      state = EMPTY;
    else if (!head_ready)           state = WAIT;
    else if (!rf_ready || flush)    state = STALL;
    else                            state = COMMIT;
  end

  assign commit = (state == COMMIT);

  always_comb begin
    unit_consume = '0;
    rf_we        = '0;
    if (commit) begin
      rf_we = head_en;
      for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
        if (head_en[i]) unit_consume[head_sels[i*SW +: SW]] = 1'b1;
      end
    end
  end

  assign wb_sels = empty ? sels_hold : head_sels;
  assign rf_rd   = empty ? rd_hold   : head_rd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sels_hold <= '0;
      rd_hold   <= '0;
    end else begin
      if (!empty) begin
        sels_hold <= head_sels;
        rd_hold   <= head_rd;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PW'(1);
        if (commit) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Storage needs no reset: it is only observed while the pointers say it is occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      sels_mem[wr_ptr[AW-1:0]] <= issue_sels;
      en_mem[wr_ptr[AW-1:0]]   <= issue_port_en;
      rd_mem[wr_ptr[AW-1:0]]   <= issue_rd;
    end
  end

`ifdef RCA_WB_TIMEOUT_EN
  logic [9:0] to_cnt;
  logic       to_err;
  logic       to_inc;

  assign to_inc = !empty && !commit && !flush;

  // The error fires on the edge where the counter reaches 1023 and then sticks until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (flush || commit)                  to_cnt <= '0;
      else if (to_inc && to_cnt != 10'h3FF) to_cnt <= to_cnt + 10'd1;
      if (to_inc && to_cnt == 10'h3FE)      to_err <= 1'b1;
    end
  end

  assign timeout_err = to_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule
